// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bundle and UART TX core handshake for uart_tx_arbiter.
// The arbiter takes the slave modport; the byte sources / TX core side take master.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_valid;
   logic [7:0]           tx_data;
   logic                 tx_ready;
   logic [GW-1:0]        grant_id;
   logic                 busy;

   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data, grant_id, busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin UART TX sharing with burst lock and MAX_BURST forced re-arbitration.
// Optional ID prefix byte per grant when UART_ARB_PREFIX_EN is defined.
module uart_tx_arbiter #(
   parameter int         NUM_REQ   = 4,
   parameter int         MAX_BURST = 16,
   parameter logic [7:0] ID_BASE   = 8'hF0
) (
   input logic               clk,
   input logic               sync_reset,
   uart_tx_arbiter_if.slave  bus
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_ARB_PREFIX_EN
   typedef enum logic [1:0] {IDLE, PREFIX, STREAM} state_t;
`else
   typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

   state_t        r_state;
   logic [GW-1:0] r_grant;
   logic [GW-1:0] r_last_grant;
   logic [7:0]    r_burst_cnt;
   logic          r_busy;

   logic          w_hit;
   logic [GW-1:0] w_pick;
   logic          w_sel_valid;
   logic          w_sel_last;
   logic [7:0]    w_sel_data;
   logic          w_xfer;
   logic          w_end;

   function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] b,
                                              input int k);
      int s;
      s = (int'(b) + k) % NUM_REQ;
      return GW'(s);
   endfunction

   // first valid requester after the last one served
   always_comb begin
      w_hit  = 1'b0;
      w_pick = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!w_hit && bus.req_valid[wrap_idx(r_last_grant, k)]) begin
            w_hit  = 1'b1;
            w_pick = wrap_idx(r_last_grant, k);
         end
      end
   end

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i == int'(r_grant)) begin
            w_sel_valid = bus.req_valid[i];
            w_sel_last  = bus.req_last[i];
            w_sel_data  = bus.req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      bus.tx_valid  = 1'b0;
      bus.tx_data   = 8'h00;
      bus.req_ready = '0;
      case (r_state)
`ifdef UART_ARB_PREFIX_EN
         PREFIX: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = ID_BASE + 8'(r_grant);
         end
`endif
         STREAM: begin
            bus.tx_valid           = w_sel_valid;
            bus.tx_data            = w_sel_data;
            bus.req_ready[r_grant] = bus.tx_ready;
         end
         default: ;
      endcase
   end

   assign w_xfer       = bus.tx_valid && bus.tx_ready;
   assign w_end        = w_sel_last || (r_burst_cnt == 8'(MAX_BURST - 1));
   assign bus.grant_id = r_grant;
   assign bus.busy     = r_busy;

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_last_grant <= GW'(NUM_REQ - 1);
         r_burst_cnt  <= 8'd0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hit) begin
                  r_grant     <= w_pick;
                  r_burst_cnt <= 8'd0;
                  r_busy      <= 1'b1;
`ifdef UART_ARB_PREFIX_EN
                  r_state     <= PREFIX;
`else
                  r_state     <= STREAM;
`endif
               end
            end
`ifdef UART_ARB_PREFIX_EN
            PREFIX: begin
               if (bus.tx_ready) r_state <= STREAM;
            end
`endif
            STREAM: begin
               if (w_xfer) begin
                  r_burst_cnt <= r_burst_cnt + 8'd1;
                  if (w_end) begin
                     r_state      <= IDLE;
                     r_last_grant <= r_grant;
                     r_busy       <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive the DUT,
// expected bytes are queued by the stimulus and checked by a monitor.
module tb_uart_tx_arbiter;
   localparam int NR = 4;
`ifdef UART_ARB_PREFIX_EN
   localparam int PFX = 1;
`else
   localparam int PFX = 0;
`endif

   typedef struct {
      logic [7:0] d;
      logic [1:0] g;
      bit         p;
   } exp_t;

   logic clk;
   logic sync_reset;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) ifc ();

   uart_tx_arbiter #(
      .NUM_REQ(NR),
      .MAX_BURST(16),
      .ID_BASE(8'hF0)
   ) dut (
      .clk(clk),
      .sync_reset(sync_reset),
      .bus(ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [8:0] rq [NR][$];
   exp_t       sbq[$];
   int         xq[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         busy_cyc = 0;

   task automatic drive();
      logic [NR-1:0]   v;
      logic [NR-1:0]   l;
      logic [8*NR-1:0] d;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < NR; i++) begin
         if (rq[i].size() != 0) begin
            v[i]         = 1'b1;
            l[i]         = rq[i][0][8];
            d[8*i +: 8]  = rq[i][0][7:0];
         end
      end
      ifc.req_valid = v;
      ifc.req_last  = l;
      ifc.req_data  = d;
   endtask

   // requester model: pop a byte after each accepted handshake
   initial begin
      logic [NR-1:0] acc;
      drive();
      forever begin
         @(negedge clk);
         acc = ifc.req_valid & ifc.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++)
            if (acc[i]) void'(rq[i].pop_front());
         drive();
      end
   end

   always @(negedge clk) begin
      exp_t          e;
      logic [NR-1:0] er;
      cyc = cyc + 1;
      if (ifc.busy) busy_cyc = busy_cyc + 1;
      if (!sync_reset && ifc.tx_valid && ifc.tx_ready) begin
         n_tests = n_tests + 1;
         if (sbq.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL extra_byte: got data %h grant %0d, expected none",
                     ifc.tx_data, ifc.grant_id);
         end else begin
            e  = sbq.pop_front();
            er = e.p ? '0 : (NR'(1) << e.g);
            if (ifc.tx_data !== e.d || ifc.grant_id !== e.g ||
                ifc.req_ready !== er) begin
               n_fail = n_fail + 1;
               $display("FAIL tx_byte: got d=%h g=%0d rdy=%b, expected d=%h g=%0d rdy=%b",
                        ifc.tx_data, ifc.grant_id, ifc.req_ready, e.d, e.g, er);
            end
            if (!e.p) xq.push_back(cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_tests = n_tests + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic send(input int r, input logic [7:0] b, input bit last);
      rq[r].push_back({last, b});
   endtask

   task automatic exp_grant(input int g);
      exp_t e;
      if (PFX != 0) begin
         e.d = 8'hF0 + 8'(g);
         e.g = 2'(g);
         e.p = 1'b1;
         sbq.push_back(e);
      end
   endtask

   task automatic exp_byte(input int g, input logic [7:0] b);
      exp_t e;
      e.d = b;
      e.g = 2'(g);
      e.p = 1'b0;
      sbq.push_back(e);
   endtask

   function automatic bit pending();
      bit r;
      r = (sbq.size() != 0) || ifc.busy;
      for (int i = 0; i < NR; i++)
         if (rq[i].size() != 0) r = 1'b1;
      return r;
   endfunction

   task automatic drain(input string nm, input int budget);
      int k;
      k = 0;
      while (pending() && k < budget) begin
         tick(1);
         k++;
      end
      n_tests = n_tests + 1;
      if (k >= budget) begin
         n_fail = n_fail + 1;
         $display("FAIL %s_drain: still pending after %0d cycles, expected idle",
                  nm, budget);
      end
      tick(2);
   endtask

   task automatic do_reset();
      sync_reset = 1'b1;
      tick(2);
      sync_reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      sync_reset   = 1'b1;
      ifc.tx_ready = 1'b0;
      tick(1);
      do_reset();

      // reset state
      @(negedge clk);
      chk("rst_tx_valid", int'(ifc.tx_valid), 0);
      chk("rst_tx_data", int'(ifc.tx_data), 0);
      chk("rst_req_ready", int'(ifc.req_ready), 0);
      chk("rst_grant_id", int'(ifc.grant_id), 0);
      chk("rst_busy", int'(ifc.busy), 0);
      tick(1);

      // 1: single requester, 3 back-to-back bytes
      ifc.tx_ready = 1'b1;
      xq.delete();
      busy_cyc = 0;
      exp_grant(0);
      exp_byte(0, 8'h11);
      exp_byte(0, 8'h22);
      exp_byte(0, 8'h33);
      send(0, 8'h11, 0);
      send(0, 8'h22, 0);
      send(0, 8'h33, 1);
      drain("t1", 50);
      chk("t1_count", xq.size(), 3);
      if (xq.size() == 3) begin
         chk("t1_gap0", xq[1] - xq[0], 1);
         chk("t1_gap1", xq[2] - xq[1], 1);
      end
      chk("t1_busy_cycles", busy_cyc, 3 + PFX);

      // 2: all four request at once, 1-byte bursts
      do_reset();
      ifc.tx_ready = 1'b1;
      xq.delete();
      for (int i = 0; i < NR; i++) begin
         exp_grant(i);
         exp_byte(i, 8'hA0 + 8'(i));
         send(i, 8'hA0 + 8'(i), 1);
      end
      drain("t2", 60);
      chk("t2_count", xq.size(), 4);
      if (xq.size() == 4)
         for (int i = 0; i < 3; i++)
            chk("t2_gap", xq[i+1] - xq[i], 2 + PFX);

      // 3: MAX_BURST forces req1 off, req2 served, req1 resumes
      do_reset();
      ifc.tx_ready = 1'b1;
      exp_grant(1);
      for (int i = 1; i <= 16; i++) exp_byte(1, 8'(i));
      exp_grant(2);
      exp_byte(2, 8'h51);
      exp_byte(2, 8'h52);
      exp_grant(1);
      for (int i = 17; i <= 20; i++) exp_byte(1, 8'(i));
      for (int i = 1; i <= 20; i++) send(1, 8'(i), i == 20);
      send(2, 8'h51, 0);
      send(2, 8'h52, 1);
      drain("t3", 200);

      // 4: tx_ready low for 5 cycles mid-burst
      do_reset();
      ifc.tx_ready = 1'b0;
      exp_grant(0);
      exp_byte(0, 8'hC1);
      exp_byte(0, 8'hC2);
      exp_byte(0, 8'hC3);
      exp_byte(0, 8'hC4);
      send(0, 8'hC1, 0);
      send(0, 8'hC2, 0);
      send(0, 8'hC3, 0);
      send(0, 8'hC4, 1);
      tick(4);
      ifc.tx_ready = 1'b1;
      tick(2 + PFX);
      ifc.tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_stall_valid", int'(ifc.tx_valid), 1);
         chk("t4_stall_data", int'(ifc.tx_data), 'hC3);
         chk("t4_stall_ready", int'(ifc.req_ready), 0);
      end
      tick(1);
      ifc.tx_ready = 1'b1;
      drain("t4", 50);

      // 5: reset after 2 of 4 bytes; req0 wins over req3 afterwards
      do_reset();
      ifc.tx_ready = 1'b0;
      exp_grant(3);
      exp_byte(3, 8'hB1);
      exp_byte(3, 8'hB2);
      send(3, 8'hB1, 0);
      send(3, 8'hB2, 0);
      send(3, 8'hB3, 0);
      send(3, 8'hB4, 1);
      tick(4);
      ifc.tx_ready = 1'b1;
      tick(2 + PFX);
      ifc.tx_ready = 1'b0;
      sync_reset   = 1'b1;
      send(0, 8'hD1, 1);
      exp_grant(0);
      exp_byte(0, 8'hD1);
      exp_grant(3);
      exp_byte(3, 8'hB3);
      exp_byte(3, 8'hB4);
      tick(1);
      sync_reset = 1'b0;
      @(negedge clk);
      chk("t5_busy", int'(ifc.busy), 0);
      chk("t5_tx_valid", int'(ifc.tx_valid), 0);
      chk("t5_tx_data", int'(ifc.tx_data), 0);
      chk("t5_req_ready", int'(ifc.req_ready), 0);
      chk("t5_grant_id", int'(ifc.grant_id), 0);
      tick(1);
      ifc.tx_ready = 1'b1;
      drain("t5", 60);

      // 6: req2 single byte; ID prefix only when the option is built in
      do_reset();
      ifc.tx_ready = 1'b1;
      exp_grant(2);
      exp_byte(2, 8'hAA);
      send(2, 8'hAA, 1);
      drain("t6", 40);

      chk("sb_leftover", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
